// File: rtl/haraka_pkg.sv
// -----------------------------------------------------------------------------
// haraka_pkg
// Shared definitions for the Haraka-S sponge front end and the downstream
// sponge controller: rate geometry, padding byte defaults and the absorb-side
// state encoding.
// -----------------------------------------------------------------------------
package haraka_pkg;

    // Rate of the sponge in bytes and in bits.
    localparam int HK_RATE_BYTES = 32;
    localparam int HK_RATE_BITS  = 8 * HK_RATE_BYTES;

    // Domain-separation byte placed right after the message, and the byte
    // folded into the last rate lane of the final block.
    localparam logic [7:0] HK_PAD_DOMAIN = 8'h1F;
    localparam logic [7:0] HK_PAD_FINAL  = 8'h80;

    // Absorb-side states.
    typedef enum logic [1:0] {
        ST_FILL         = 2'd0,
        ST_EMIT         = 2'd1,
        ST_EMIT_PADONLY = 2'd2,
        ST_SQUEEZE      = 2'd3
    } absorb_state_t;

endpackage

// File: rtl/haraka_s_absorb_padder.sv
// -----------------------------------------------------------------------------
// haraka_s_absorb_padder
// Packs a byte stream into rate blocks, applies sponge padding, hands each
// block to the absorb stage over valid/ready and pulses squeeze_start once the
// final padded block has been taken.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   in_byte         : message byte
//   in_valid        : in_byte / in_last / in_keep are valid
//   in_last         : final beat of the message
//   in_keep         : beat carries a byte (0 = end marker without a byte)
//   in_ready        : beat is accepted this cycle (depends on state only)
//   block_out       : rate block, lane i at bits [W-1-8i -: 8]
//   block_valid     : block_out / block_last are valid
//   block_last      : block carries the final padding
//   block_ready     : consumer accepts the block
//   squeeze_start   : one-cycle pulse after the last block handshake
// -----------------------------------------------------------------------------
module haraka_s_absorb_padder
    import haraka_pkg::*;
#(
    parameter int         RATE_BYTES = HK_RATE_BYTES,
    parameter logic [7:0] PAD_DOMAIN = HK_PAD_DOMAIN,
    parameter logic [7:0] PAD_FINAL  = HK_PAD_FINAL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    in_keep,
    output logic                    in_ready,
    output logic [8*RATE_BYTES-1:0] block_out,
    output logic                    block_valid,
    output logic                    block_last,
    input  logic                    block_ready,
    output logic                    squeeze_start
);

    localparam int                W        = 8 * RATE_BYTES;
    localparam int                IDXW     = $clog2(RATE_BYTES);
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(RATE_BYTES - 1);
    localparam logic [IDXW-1:0]   IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0]   IDX_ZERO = IDXW'(0);

    // XOR a byte into one lane. Unwritten lanes are always zero, so the same
    // helper serves both for writing message bytes and for folding in pads;
    // when domain and final pad hit the same lane they combine (0x9F).
    function automatic logic [W-1:0] lane_xor(input logic [W-1:0]    blk,
                                               input logic [IDXW-1:0] lane,
                                               input logic [7:0]      val);
        logic [W-1:0] r;
        r = blk;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (lane == IDXW'(i)) begin
                r[W-1-8*i -: 8] = r[W-1-8*i -: 8] ^ val;
            end
        end
        return r;
    endfunction

    absorb_state_t       state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [W-1:0]        buf_q, buf_d;
    logic                last_q, last_d;
    logic                pend_q, pend_d;
    logic                in_ready_q, in_ready_d;
    logic                valid_q, valid_d;
    logic                sq_q, sq_d;

    // Next-state, buffer update and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        last_d  = last_q;
        pend_d  = pend_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid && in_ready_q) begin
                    idx_d = idx_q + IDX_ONE;
                    if (in_keep) begin
                        buf_d = lane_xor(buf_q, idx_q, in_byte);
                        if (in_last) begin
                            state_d = ST_EMIT;
                            idx_d   = IDX_ZERO;
                            if (idx_q == LAST_IDX) begin
                                // No room left for padding: emit the full
                                // block now and a pad-only block after it.
                                pend_d = 1'b1;
                                last_d = 1'b0;
                            end else begin
                                buf_d  = lane_xor(lane_xor(buf_d, idx_q + IDX_ONE, PAD_DOMAIN),
                                                  LAST_IDX, PAD_FINAL);
                                last_d = 1'b1;
                            end
                        end else if (idx_q == LAST_IDX) begin
                            // idx_d wraps to zero through the adder.
                            state_d = ST_EMIT;
                            last_d  = 1'b0;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        // Byte-less end marker: padding starts at idx itself.
                        buf_d   = lane_xor(lane_xor(buf_q, idx_q, PAD_DOMAIN), LAST_IDX, PAD_FINAL);
                        state_d = ST_EMIT;
                        last_d  = 1'b1;
                        idx_d   = IDX_ZERO;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_EMIT: begin
                if (valid_q && block_ready) begin
                    if (pend_q) begin
                        state_d = ST_EMIT_PADONLY;
                        pend_d  = 1'b0;
                        last_d  = 1'b1;
                        buf_d   = lane_xor(lane_xor('0, IDX_ZERO, PAD_DOMAIN), LAST_IDX, PAD_FINAL);
                    end else if (last_q) begin
                        state_d = ST_SQUEEZE;
                    end else begin
                        state_d = ST_FILL;
                        buf_d   = '0;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT_PADONLY: begin
                if (valid_q && block_ready) begin
                    state_d = ST_SQUEEZE;
                end else begin
                    state_d = ST_EMIT_PADONLY;
                end
            end
            ST_SQUEEZE: begin
                state_d = ST_FILL;
                idx_d   = IDX_ZERO;
                buf_d   = '0;
                last_d  = 1'b0;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = ST_FILL;
                idx_d   = IDX_ZERO;
                buf_d   = '0;
                last_d  = 1'b0;
                pend_d  = 1'b0;
            end
        endcase

        // Handshake outputs are registered copies of the next state, so
        // in_ready never depends combinationally on block_ready.
        in_ready_d = (state_d == ST_FILL);
        valid_d    = (state_d == ST_EMIT) || (state_d == ST_EMIT_PADONLY);
        sq_d       = (state_d == ST_SQUEEZE);
    end

    // State and output registers; reset discards any partial block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            idx_q      <= IDX_ZERO;
            buf_q      <= '0;
            last_q     <= 1'b0;
            pend_q     <= 1'b0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            sq_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
            sq_q       <= sq_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign block_out     = buf_q;
    assign block_valid   = valid_q;
    assign block_last    = last_q;
    assign squeeze_start = sq_q;

endmodule

// File: tb/tb_haraka_s_absorb_padder.sv
// -----------------------------------------------------------------------------
// tb_haraka_s_absorb_padder
// Directed bench for the Haraka-S absorb padder. Blocks taken by the consumer
// are recorded by a negedge monitor; each test task compares them against
// hand-built expected blocks.
// -----------------------------------------------------------------------------
module tb_haraka_s_absorb_padder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_byte = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_keep = 1'b0;
    wire          in_ready;
    wire  [255:0] block_out;
    wire          block_valid;
    wire          block_last;
    wire          squeeze_start;

    logic         ready_force = 1'b0;
    logic         stall_mode = 1'b0;
    logic         rnd_ready = 1'b0;
    wire          block_ready = stall_mode ? rnd_ready : ready_force;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sq_count = 0;
    int sq_cyc = 0;
    int stall_viol = 0;
    int to_cnt = 0;

    logic [255:0] blk_q[$];
    logic         blast_q[$];
    int           blk_sq_q[$];
    logic         stall_prev = 1'b0;
    logic [255:0] out_prev = '0;
    logic         last_prev = 1'b0;

    always #5 clk = ~clk;

    haraka_s_absorb_padder dut (
        .clk           (clk),
        .reset         (reset),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_keep       (in_keep),
        .in_ready      (in_ready),
        .block_out     (block_out),
        .block_valid   (block_valid),
        .block_last    (block_last),
        .block_ready   (block_ready),
        .squeeze_start (squeeze_start)
    );

    // Cycle counter, read #1 after an edge or at the negedge.
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer readiness used while stall_mode is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: record handshaken blocks, squeeze pulses and stall stability.
    always @(negedge clk) begin
        if (block_valid && block_ready) begin
            blk_q.push_back(block_out);
            blast_q.push_back(block_last);
            blk_sq_q.push_back(sq_count);
        end
        if (squeeze_start) begin
            sq_count <= sq_count + 1;
            sq_cyc   <= cyc;
        end
        if (stall_prev && block_valid && (block_out !== out_prev || block_last !== last_prev))
            stall_viol <= stall_viol + 1;
        stall_prev <= block_valid && !block_ready;
        out_prev   <= block_out;
        last_prev  <= block_last;
    end

    function automatic logic [255:0] lane_set(input logic [255:0] b, input int lane, input logic [7:0] v);
        logic [255:0] r;
        r = b;
        r[255-8*lane -: 8] = v;
        return r;
    endfunction

    // Present one beat, wait (bounded) for in_ready, pass the accepting edge.
    // acc = cycle number read just after the accepting edge.
    task automatic send_beat(input logic [7:0] b, input logic last, input logic keep, output int acc);
        int n;
        n = 0;
        in_byte  = b;
        in_last  = last;
        in_keep  = keep;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) to_cnt++;
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_keep  = 1'b0;
    endtask

    task automatic wait_blocks(input int n);
        int k;
        k = 0;
        while (blk_q.size() < n && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int acc, b0, sq0;
        logic [255:0] e;
        reset = 1'b1;
        ready_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", block_valid); end
        checks++; if (block_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", block_last); end
        checks++; if (squeeze_start !== 1'b0) begin errors++; $display("FAIL rst_squeeze: got %b want 0", squeeze_start); end
        checks++; if (block_out !== 256'h0) begin errors++; $display("FAIL rst_block: got %h want 0", block_out); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
        // Reset mid-fill.
        for (int i = 0; i < 10; i++) send_beat(8'(i + 1), 1'b0, 1'b1, acc);
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midfill_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Reset mid-EMIT: full block held by a stalled consumer.
        for (int i = 0; i < 32; i++) send_beat(8'(i + 8'h21), 1'b0, 1'b1, acc);
        checks++; if (block_valid !== 1'b1) begin errors++; $display("FAIL emit_valid: got %b want 1", block_valid); end
        reset = 1'b1;
        #1;
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL midemit_valid: got %b want 0", block_valid); end
        checks++; if (block_out !== 256'h0) begin errors++; $display("FAIL midemit_block: got %h want 0", block_out); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        b0  = blk_q.size();
        sq0 = sq_count;
        checks++; if (b0 !== 0 || sq0 !== 0) begin errors++; $display("FAIL rst_no_output: got blocks=%0d squeezes=%0d want 0/0", b0, sq0); end
        ready_force = 1'b1;
        send_beat(8'hAA, 1'b0, 1'b1, acc);
        send_beat(8'hBB, 1'b0, 1'b1, acc);
        send_beat(8'hCC, 1'b1, 1'b1, acc);
        wait_blocks(b0 + 1);
        e = '0;
        e = lane_set(e, 0, 8'hAA); e = lane_set(e, 1, 8'hBB); e = lane_set(e, 2, 8'hCC);
        e = lane_set(e, 3, 8'h1F); e = lane_set(e, 31, 8'h80);
        checks++; if (blk_q.size() !== b0 + 1) begin errors++; $display("FAIL post_rst_count: got %0d want %0d", blk_q.size(), b0 + 1); end
        else begin
            checks++; if (blk_q[b0] !== e) begin errors++; $display("FAIL post_rst_block: got %h want %h", blk_q[b0], e); end
            checks++; if (blast_q[b0] !== 1'b1) begin errors++; $display("FAIL post_rst_last: got %b want 1", blast_q[b0]); end
        end
    endtask

    task automatic test_empty();
        int acc, b0, sq0;
        logic [255:0] e;
        b0 = blk_q.size();
        sq0 = sq_count;
        ready_force = 1'b1;
        send_beat(8'h00, 1'b1, 1'b0, acc);
        wait_blocks(b0 + 1);
        e = '0;
        e = lane_set(e, 0, 8'h1F); e = lane_set(e, 31, 8'h80);
        checks++; if (blk_q.size() !== b0 + 1) begin errors++; $display("FAIL empty_count: got %0d want %0d", blk_q.size(), b0 + 1); end
        else begin
            checks++; if (blk_q[b0] !== e) begin errors++; $display("FAIL empty_block: got %h want %h", blk_q[b0], e); end
            checks++; if (blast_q[b0] !== 1'b1) begin errors++; $display("FAIL empty_last: got %b want 1", blast_q[b0]); end
        end
        checks++; if (sq_count !== sq0 + 1) begin errors++; $display("FAIL empty_squeeze: got %0d want %0d", sq_count, sq0 + 1); end
        // Accepting edge -> EMIT cycle -> SQUEEZE cycle.
        checks++; if (sq_cyc !== acc + 1) begin errors++; $display("FAIL squeeze_latency: got cycle %0d want %0d", sq_cyc, acc + 1); end
    endtask

    task automatic test_31_bytes();
        int acc, b0;
        logic [255:0] e;
        b0 = blk_q.size();
        ready_force = 1'b1;
        e = '0;
        for (int i = 0; i < 31; i++) begin
            send_beat(8'(i), (i == 30), 1'b1, acc);
            e = lane_set(e, i, 8'(i));
        end
        // Byte 0x1E sits in lane 30; lane 31 takes both pads: 0x1F ^ 0x80.
        e = lane_set(e, 31, 8'h9F);
        wait_blocks(b0 + 1);
        checks++; if (blk_q.size() !== b0 + 1) begin errors++; $display("FAIL b31_count: got %0d want %0d", blk_q.size(), b0 + 1); end
        else begin
            checks++; if (blk_q[b0] !== e) begin errors++; $display("FAIL b31_block: got %h want %h", blk_q[b0], e); end
            checks++; if (blast_q[b0] !== 1'b1) begin errors++; $display("FAIL b31_last: got %b want 1", blast_q[b0]); end
        end
    endtask

    task automatic test_32_bytes();
        int acc, b0, sq0;
        logic [255:0] e1, e2;
        b0 = blk_q.size();
        sq0 = sq_count;
        ready_force = 1'b1;
        e1 = '0;
        for (int i = 0; i < 32; i++) begin
            send_beat(8'(i), (i == 31), 1'b1, acc);
            e1 = lane_set(e1, i, 8'(i));
        end
        e2 = '0;
        e2 = lane_set(e2, 0, 8'h1F); e2 = lane_set(e2, 31, 8'h80);
        wait_blocks(b0 + 2);
        checks++; if (blk_q.size() !== b0 + 2) begin errors++; $display("FAIL b32_count: got %0d want %0d", blk_q.size(), b0 + 2); end
        else begin
            checks++; if (blk_q[b0] !== e1) begin errors++; $display("FAIL b32_block1: got %h want %h", blk_q[b0], e1); end
            checks++; if (blast_q[b0] !== 1'b0) begin errors++; $display("FAIL b32_last1: got %b want 0", blast_q[b0]); end
            checks++; if (blk_q[b0+1] !== e2) begin errors++; $display("FAIL b32_block2: got %h want %h", blk_q[b0+1], e2); end
            checks++; if (blast_q[b0+1] !== 1'b1) begin errors++; $display("FAIL b32_last2: got %b want 1", blast_q[b0+1]); end
            checks++; if (blk_sq_q[b0+1] !== sq0) begin errors++; $display("FAIL b32_early_squeeze: got %0d want %0d", blk_sq_q[b0+1], sq0); end
        end
        checks++; if (sq_count !== sq0 + 1) begin errors++; $display("FAIL b32_squeeze: got %0d want %0d", sq_count, sq0 + 1); end
    endtask

    task automatic test_stall_69();
        int acc, b0, v0, sq0;
        logic [255:0] e[3];
        b0 = blk_q.size();
        v0 = stall_viol;
        sq0 = sq_count;
        for (int k = 0; k < 3; k++) e[k] = '0;
        stall_mode = 1'b1;
        for (int i = 0; i < 69; i++) begin
            send_beat(8'(i * 5 + 1), (i == 68), 1'b1, acc);
            e[i / 32] = lane_set(e[i / 32], i % 32, 8'(i * 5 + 1));
        end
        e[2] = lane_set(e[2], 5, 8'h1F);
        e[2] = lane_set(e[2], 31, 8'h80);
        wait_blocks(b0 + 3);
        stall_mode = 1'b0;
        checks++; if (blk_q.size() !== b0 + 3) begin errors++; $display("FAIL stall_count: got %0d want %0d", blk_q.size(), b0 + 3); end
        else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (blk_q[b0+k] !== e[k]) begin errors++; $display("FAIL stall_block%0d: got %h want %h", k, blk_q[b0+k], e[k]); end
                checks++; if (blast_q[b0+k] !== (k == 2)) begin errors++; $display("FAIL stall_last%0d: got %b want %b", k, blast_q[b0+k], (k == 2)); end
            end
        end
        checks++; if (stall_viol !== v0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol - v0); end
        checks++; if (sq_count !== sq0 + 1) begin errors++; $display("FAIL stall_squeeze: got %0d want %0d", sq_count, sq0 + 1); end
    endtask

    task automatic test_back_to_back();
        int acc, acc31, acc32, acc_m2, b0, sq0;
        logic [255:0] e1, e2, e3;
        b0 = blk_q.size();
        sq0 = sq_count;
        ready_force = 1'b1;
        e1 = '0;
        acc31 = 0;
        for (int i = 0; i < 32; i++) begin
            send_beat(8'(i + 8'h40), 1'b0, 1'b1, acc);
            e1 = lane_set(e1, i, 8'(i + 8'h40));
            acc31 = acc;
        end
        send_beat(8'h60, 1'b1, 1'b1, acc32);
        // One EMIT cycle between lane 31 and the next lane 0 acceptance.
        checks++; if (acc32 - acc31 !== 2) begin errors++; $display("FAIL full_gap: got %0d cycles want 2", acc32 - acc31); end
        // Present message 2 while message 1 is emitting / squeezing.
        in_byte = 8'h55; in_last = 1'b1; in_keep = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (squeeze_start !== 1'b1) begin errors++; $display("FAIL b2b_squeeze: got %b want 1", squeeze_start); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
        send_beat(8'h55, 1'b1, 1'b1, acc_m2);
        checks++; if (acc_m2 !== acc32 + 3) begin errors++; $display("FAIL b2b_accept: got cycle %0d want %0d", acc_m2, acc32 + 3); end
        wait_blocks(b0 + 3);
        e2 = '0;
        e2 = lane_set(e2, 0, 8'h60); e2 = lane_set(e2, 1, 8'h1F); e2 = lane_set(e2, 31, 8'h80);
        e3 = '0;
        e3 = lane_set(e3, 0, 8'h55); e3 = lane_set(e3, 1, 8'h1F); e3 = lane_set(e3, 31, 8'h80);
        checks++; if (blk_q.size() !== b0 + 3) begin errors++; $display("FAIL b2b_count: got %0d want %0d", blk_q.size(), b0 + 3); end
        else begin
            checks++; if (blk_q[b0] !== e1) begin errors++; $display("FAIL b2b_block1: got %h want %h", blk_q[b0], e1); end
            checks++; if (blk_q[b0+1] !== e2) begin errors++; $display("FAIL b2b_block2: got %h want %h", blk_q[b0+1], e2); end
            checks++; if (blk_q[b0+2] !== e3) begin errors++; $display("FAIL b2b_block3: got %h want %h", blk_q[b0+2], e3); end
            checks++; if (blast_q[b0+2] !== 1'b1) begin errors++; $display("FAIL b2b_last3: got %b want 1", blast_q[b0+2]); end
        end
        checks++; if (sq_count !== sq0 + 2) begin errors++; $display("FAIL b2b_squeezes: got %0d want %0d", sq_count, sq0 + 2); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_31_bytes();
        test_32_bytes();
        test_stall_69();
        test_back_to_back();
        checks++; if (to_cnt !== 0) begin errors++; $display("FAIL in_ready_timeout: got %0d timeouts want 0", to_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
